// File: rtl/multibyte_add_seq.sv
// ---------------------------------------------------------------------------
// multibyte_add_seq
//   Sequential W-bit adder (W = 8*NBYTES) built around a single 8-bit adder.
//   The operands are added one byte per clock, LSB byte first. The carry
//   between bytes is registered. The visible result registers (sum, cout,
//   ovf) change only when the last byte completes, so partial sums never
//   appear on the outputs.
//
//   Ports
//     clk    in   1  clock; all state changes on its rising edge
//     rst    in   1  asynchronous active-high reset
//     start  in   1  begin one addition; accepted only in IDLE or DONE
//     op_a   in   W  first operand
//     op_b   in   W  second operand
//     cin    in   1  carry into byte 0
//     busy   out  1  high while bytes are being added (ADD state)
//     done   out  1  one-cycle pulse when sum/cout/ovf have been updated
//     sum    out  W  registered result
//     cout   out  1  carry out of the most significant byte
//     ovf    out  1  signed overflow of the W-bit addition
// ---------------------------------------------------------------------------

// 8-bit ripple adder used once per byte.
module adder_8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] Sum,
    output logic       Cout
);
    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {8'b0, Cin};
endmodule

module multibyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
);
    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q;
    logic [W-1:0]       a_q, b_q;
    logic [W-1:0]       res_q, res_d;
    logic [W-1:0]       sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic               capture;
    logic               last_byte;
    logic [7:0]         add_a, add_b, add_sum;
    logic               add_cout;
    logic               ovf_d;

    // Byte selection: the byte index scaled by 8 picks the current lane.
    assign add_a     = a_q[{idx_q, 3'b000} +: 8];
    assign add_b     = b_q[{idx_q, 3'b000} +: 8];
    assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

    // carry_q holds the captured cin for byte 0 and the registered
    // inter-byte carry afterwards, so a single Cin source suffices.
    adder_8bit u_adder (
        .A    (add_a),
        .B    (add_b),
        .Cin  (carry_q),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    // Working result with the current byte merged in; on the last byte this
    // is the complete sum that is published to the outputs.
    always_comb begin
        res_d = res_q;
        if (state_q == S_ADD) begin
            res_d[{idx_q, 3'b000} +: 8] = add_sum;
        end
    end

    assign ovf_d = (a_q[W-1] == b_q[W-1]) && (res_d[W-1] != a_q[W-1]);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ADD;
                    idx_d   = '0;
                    capture = 1'b1;
                end
            end
            S_ADD: begin
                // start is deliberately not looked at here.
                if (last_byte) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_ADD;
                    idx_d   = '0;
                    capture = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Control and visible result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (capture) begin
                carry_q <= cin;
            end else if (state_q == S_ADD) begin
                carry_q <= add_cout;
            end
            if (state_q == S_ADD && last_byte) begin
                sum_q  <= res_d;
                cout_q <= add_cout;
                ovf_q  <= ovf_d;
            end
        end
    end

    // Operand capture and working result; every byte of res_q is rewritten
    // before it is published, so these need no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            a_q <= op_a;
            b_q <= op_b;
        end
        if (state_q == S_ADD) begin
            res_q <= res_d;
        end
    end

    assign busy = (state_q == S_ADD);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
module tb_multibyte_add_seq;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         cin;
    logic         busy, done;
    logic [W-1:0] sum;
    logic         cout, ovf;

    int n_vec = 0;
    int n_err = 0;

    multibyte_add_seq #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain wide addition, result packed as {ovf, cout, sum}.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic c);
        logic [W:0] t;
        logic       v;
        t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        v = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return {v, t};
    endfunction

    // Launch one operation from an idle state and wait for done (bounded).
    // Operands are scrambled after acceptance to show they were captured.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, output int lat, output int nbusy,
                          output logic leak);
        logic [W-1:0] prev;
        @(negedge clk);
        op_a = a; op_b = b; cin = c; start = 1'b1;
        prev  = sum;
        lat   = -1;
        nbusy = 0;
        leak  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                op_a  = $urandom;
                op_b  = $urandom;
                cin   = 1'($urandom);
            end
            if (busy) nbusy++;
            if (!done && sum !== prev) leak = 1'b1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int waited;
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        #2;
        n_vec++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                     busy, done, sum, cout, ovf);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        op_a = 32'd3; op_b = 32'd4; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL first_start_accept: got busy=%b expected 1", busy);
        end
        waited = 0;
        while (done !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_vec++;
        if (done !== 1'b1 || sum !== 32'd7) begin
            n_err++;
            $display("FAIL first_op_sum: got done=%b sum=%h expected done=1 sum=00000007", done, sum);
        end
    endtask

    task automatic test_directed();
        int lat, nb;
        logic leak;
        // Carry ripples through every byte.
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat, nb, leak);
        n_vec++;
        if (lat !== 5 || nb !== 4) begin
            n_err++;
            $display("FAIL latency_busy: got lat=%0d busy_cycles=%0d expected lat=5 busy_cycles=4", lat, nb);
        end
        n_vec++;
        if ({ovf, cout, sum} !== {1'b0, 1'b1, 32'h00000000}) begin
            n_err++;
            $display("FAIL wrap_all_ones: got sum=%h cout=%b ovf=%b expected sum=00000000 cout=1 ovf=0", sum, cout, ovf);
        end
        n_vec++;
        @(negedge clk);
        if (done !== 1'b0 || sum !== 32'h00000000 || cout !== 1'b1) begin
            n_err++;
            $display("FAIL hold_after_done: got done=%b sum=%h cout=%b expected done=0 sum=00000000 cout=1", done, sum, cout);
        end
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat, nb, leak);
        n_vec++;
        if ({ovf, cout, sum} !== {1'b1, 1'b0, 32'h80000000}) begin
            n_err++;
            $display("FAIL signed_ovf: got sum=%h cout=%b ovf=%b expected sum=80000000 cout=0 ovf=1", sum, cout, ovf);
        end
        run_op(32'h000000FF, 32'h00000000, 1'b1, lat, nb, leak);
        n_vec++;
        if ({ovf, cout, sum} !== {1'b0, 1'b0, 32'h00000100}) begin
            n_err++;
            $display("FAIL cin_byte_carry: got sum=%h cout=%b ovf=%b expected sum=00000100 cout=0 ovf=0", sum, cout, ovf);
        end
        n_vec++;
        if (leak !== 1'b0) begin
            n_err++;
            $display("FAIL partial_on_sum: got leak=%b expected 0", leak);
        end
    endtask

    task automatic test_random();
        int lat, nb;
        logic leak;
        logic [W-1:0] a, b;
        logic c;
        logic [W+1:0] exp;
        for (int i = 0; i < 25; i++) begin
            a = $urandom;
            b = $urandom;
            c = 1'($urandom);
            case (i % 6)
                0: begin a = '1; b = '1; end
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; c = 1'b0; end
                2: begin a = 32'h00FF00FF; b = 32'h00010001; end
                default: ;
            endcase
            exp = ref_add(a, b, c);
            run_op(a, b, c, lat, nb, leak);
            n_vec++;
            if ({ovf, cout, sum} !== exp || lat !== 5 || leak !== 1'b0) begin
                n_err++;
                $display("FAIL random_%0d: a=%h b=%h cin=%b got ovf/cout/sum=%b/%b/%h lat=%0d leak=%b expected %b/%b/%h lat=5 leak=0",
                         i, a, b, c, ovf, cout, sum, lat, leak, exp[W+1], exp[W], exp[W-1:0]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        logic [W-1:0] got;
        @(negedge clk);
        op_a = 32'h12345678; op_b = 32'h11111111; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op_a = 32'hDEADBEEF; op_b = 32'h01010101;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        got   = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                got = sum;
            end
        end
        n_vec++;
        if (ndone !== 1 || got !== 32'h23456789) begin
            n_err++;
            $display("FAIL start_in_add_ignored: got done_pulses=%0d sum=%h expected 1 and 23456789", ndone, got);
        end
    endtask

    task automatic test_back_to_back();
        int first, second;
        logic [W-1:0] s1, s2;
        logic gap_bad;
        first = -1; second = -1; s1 = '0; s2 = '0; gap_bad = 1'b0;
        @(negedge clk);
        op_a = 32'h1; op_b = 32'h1; cin = 1'b0; start = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) begin op_a = 32'hFF; op_b = 32'h1; end
            if (done) begin
                if (first < 0) begin first = i; s1 = sum; end
                else if (second < 0) begin second = i; s2 = sum; end
            end else if (first >= 0 && second < 0 && !busy) begin
                gap_bad = 1'b1;
            end
            if (first >= 0 && i > first) start = 1'b0;
        end
        start = 1'b0;
        n_vec++;
        if (first !== 5 || second !== 10) begin
            n_err++;
            $display("FAIL b2b_spacing: got done at %0d and %0d expected 5 and 10", first, second);
        end
        n_vec++;
        if (s1 !== 32'h2 || s2 !== 32'h100) begin
            n_err++;
            $display("FAIL b2b_sums: got %h then %h expected 00000002 then 00000100", s1, s2);
        end
        n_vec++;
        if (gap_bad !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_busy_gap: got idle gap=%b expected 0", gap_bad);
        end
    endtask

    task automatic test_reset_mid_add();
        int lat, nb, stray;
        logic leak;
        run_op(32'h0F0F0F0F, 32'h01010101, 1'b0, lat, nb, leak);
        n_vec++;
        if (sum !== 32'h10101010) begin
            n_err++;
            $display("FAIL pre_abort_sum: got %h expected 10101010", sum);
        end
        @(negedge clk);
        op_a = 32'h11111111; op_b = 32'h22222222; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL third_add_busy: got busy=%b expected 1", busy);
        end
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            n_err++;
            $display("FAIL async_abort: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                     busy, done, sum, cout, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy || sum !== '0) stray++;
        end
        n_vec++;
        if (stray !== 0) begin
            n_err++;
            $display("FAIL no_done_after_abort: got %0d active cycles expected 0", stray);
        end
        run_op(32'h80000000, 32'h80000000, 1'b0, lat, nb, leak);
        n_vec++;
        if ({ovf, cout, sum} !== {1'b1, 1'b1, 32'h0} || lat !== 5) begin
            n_err++;
            $display("FAIL post_abort_op: got sum=%h cout=%b ovf=%b lat=%0d expected sum=00000000 cout=1 ovf=1 lat=5",
                     sum, cout, ovf, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_add();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multibyte_add_seq.md
MULTIBYTE_ADD_SEQ -- requirements
Module: multibyte_add_seq

Interface
REQ-001 Parameter NBYTES, default 4, SHALL set the number of bytes per operand; operand width W = 8*NBYTES; legal range 1..16.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to begin one addition; sampled on rising clk.
REQ-005 op_a  input  W  first operand, unsigned/two's-complement.
REQ-006 op_b  input  W  second operand.
REQ-007 cin  input  1  carry into byte 0.
REQ-008 busy  output  1  high while bytes are being added.
REQ-009 done  output  1  one-cycle pulse when sum/cout/ovf are updated.
REQ-010 sum  output  W  registered result.
REQ-011 cout  output  1  carry out of byte NBYTES-1.
REQ-012 ovf  output  1  signed overflow of the W-bit addition.

Function
REQ-013 Block SHALL instantiate exactly one adder_8bit (ports A, B, Cin, Sum, Cout) and perform the W-bit add one byte per cycle, LSB byte first.
REQ-014 FSM SHALL have states IDLE, ADD, DONE; IDLE->ADD on start=1; ADD->ADD while byte index < NBYTES-1; ADD->DONE after byte NBYTES-1; DONE->ADD on start=1, else DONE->IDLE.
REQ-015 start SHALL be accepted only in IDLE or DONE; start in ADD SHALL be ignored with no effect on the operation in progress.
REQ-016 On acceptance, op_a, op_b, cin SHALL be captured into internal registers; input changes afterwards SHALL NOT affect the result.
REQ-017 In ADD at index k: adder A = captured op_a[8k+7:8k], B = captured op_b[8k+7:8k], Cin = cin for k=0, else carry registered from byte k-1.
REQ-018 Adder Sum for byte k SHALL be stored in an internal result register; adder Cout SHALL be registered as the carry for byte k+1.
REQ-019 busy SHALL be 1 exactly in ADD; done SHALL be 1 exactly in DONE.
REQ-020 sum, cout, ovf SHALL update only on the ADD->DONE edge and hold until the next ADD->DONE edge; partial results SHALL never appear on sum.
REQ-021 ovf SHALL equal (a[W-1]==b[W-1]) AND (sum[W-1]!=a[W-1]) using captured operands.
REQ-022 Latency: with start high at rising edge T0, busy SHALL be high for edges T0+1..T0+NBYTES and done SHALL be high after edge T0+NBYTES, i.e. done visible NBYTES+1 cycles after the start edge is counted including the DONE cycle; NBYTES=4 -> done high in the 5th cycle after start.
REQ-023 Back-to-back: start high during DONE SHALL launch the next operation with no idle cycle; done SHALL then pulse every NBYTES+1 cycles.
REQ-024 Byte index SHALL wrap to 0 on every accepted start; no carry SHALL leak between operations.
REQ-025 NBYTES=1 SHALL produce a single ADD cycle and be functionally identical to a registered adder_8bit.

Reset
REQ-026 rst=1 SHALL immediately (without clk) force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, byte index=0, internal carry=0.
REQ-027 rst asserted mid-ADD SHALL abort the operation; no done pulse and no sum update SHALL follow after rst deasserts.
REQ-028 First start SHALL be accepted on the first rising clk at which rst is low.

Verification
REQ-029 op_a=0xFFFFFFFF, op_b=0x00000001, cin=0, start 1 cycle -> busy 4 cycles, done 1 cycle, sum=0x00000000, cout=1, ovf=0.
REQ-030 op_a=0x7FFFFFFF, op_b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1; then op_a=0x000000FF, op_b=0, cin=1 -> sum=0x00000100, cout=0, ovf=0 (inter-byte carry).
REQ-031 start with 0x12345678+0x11111111, change op_a/op_b and pulse start again during ADD -> second start ignored, sum=0x23456789, exactly one done pulse.
REQ-032 start held high continuously with operand pairs 0x1+0x1 then 0xFF+0x1 -> done pulses 5 cycles apart, sums 0x00000002 then 0x00000100, busy never low between them for more than the DONE cycle.
REQ-033 rst asserted asynchronously at mid-cycle during 3rd ADD cycle -> all outputs 0 before next clk edge, no done afterwards; subsequent 0x80000000+0x80000000 -> sum=0, cout=1, ovf=1.
